// File: rtl/fir_filter_prog_if.sv
// Stream + coefficient-port bundle for fir_filter_prog.
// Master drives samples/coefficients and consumes results; slave is the filter.
interface fir_filter_prog_if #(
    parameter int COEF_WIDTH     = 3,
    parameter int DATA_IN_WIDTH  = 8,
    parameter int DATA_OUT_WIDTH = 19,
    parameter int ADDR_W         = 2
);
    logic                             coef_wr_en;
    logic        [ADDR_W-1:0]         coef_addr;
    logic signed [COEF_WIDTH-1:0]     coef_wdata;
    logic                             in_valid;
    logic                             in_ready;
    logic signed [DATA_IN_WIDTH-1:0]  data_in;
    logic                             out_valid;
    logic                             out_ready;
    logic signed [DATA_OUT_WIDTH-1:0] data_out;
    logic                             sat_flag;

    modport master (
        output coef_wr_en, coef_addr, coef_wdata, in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, sat_flag
    );

    modport slave (
        input  coef_wr_en, coef_addr, coef_wdata, in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, sat_flag
    );
endinterface

// File: rtl/fir_filter_prog.sv
// Programmable signed FIR with valid/ready streams, a one-deep output slot,
// round-half-up output shift and saturation.
module fir_filter_prog #(
    parameter int NUM_TAPS       = 3,
    parameter int COEF_WIDTH     = 3,
    parameter int DATA_IN_WIDTH  = 8,
    parameter int DATA_OUT_WIDTH = 19,
    parameter int OUT_SHIFT      = 0
) (
    input logic              clk,
    input logic              rst_n,
    input logic              clk_en,
    fir_filter_prog_if.slave bus
);
    localparam int AW    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int PW    = DATA_IN_WIDTH + COEF_WIDTH;
    localparam int ACC_W = PW + $clog2(NUM_TAPS);
    // Post-processing width: room for the rounding carry and for the output range.
    localparam int SW    = ((ACC_W + 1 > DATA_OUT_WIDTH) ? ACC_W + 1 : DATA_OUT_WIDTH) + 1;
    localparam logic signed [SW-1:0] RND   = SW'((SW'(1) << OUT_SHIFT) >> 1);
    localparam logic signed [SW-1:0] MAX_V = (SW'(1) << (DATA_OUT_WIDTH - 1)) - SW'(1);
    localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

    logic [NUM_TAPS-1:0][DATA_IN_WIDTH-1:0] x_q, x_new;
    logic [NUM_TAPS-1:0][COEF_WIDTH-1:0]    c_q;
    logic [NUM_TAPS-1:0][PW-1:0]            prod;
    logic signed [ACC_W-1:0]                acc;
    logic signed [SW-1:0]                   acc_x, rnd, shd;
    logic signed [DATA_OUT_WIDTH-1:0]       y_sat, data_out_q;
    logic                                   y_clip, sat_q, out_valid_q, accept;

    assign bus.in_ready  = rst_n && clk_en && (!out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.sat_flag  = sat_q;
    assign accept        = bus.in_valid && bus.in_ready;

    // Result is formed from the line as it will look after this accept.
    always_comb begin
        x_new[0] = bus.data_in;
        for (int k = 1; k < NUM_TAPS; k++) x_new[k] = x_q[k-1];
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        assign prod[k] = PW'($signed(x_new[k])) * PW'($signed(c_q[k]));
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < NUM_TAPS; k++) acc = acc + ACC_W'($signed(prod[k]));
    end

    always_comb begin
        acc_x  = SW'(acc);
        rnd    = acc_x + RND;
        shd    = rnd >>> OUT_SHIFT;
        y_clip = 1'b0;
        y_sat  = shd[DATA_OUT_WIDTH-1:0];
        if (shd > MAX_V) begin
            y_sat  = MAX_V[DATA_OUT_WIDTH-1:0];
            y_clip = 1'b1;
        end else if (shd < MIN_V) begin
            y_sat  = MIN_V[DATA_OUT_WIDTH-1:0];
            y_clip = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q         <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            sat_q       <= 1'b0;
        end else if (clk_en) begin
            // Out-of-range addresses match no tap and are dropped.
            if (bus.coef_wr_en)
                for (int k = 0; k < NUM_TAPS; k++)
                    if (bus.coef_addr == AW'(k)) c_q[k] <= bus.coef_wdata;
            if (accept) begin
                x_q         <= x_new;
                out_valid_q <= 1'b1;
                data_out_q  <= y_sat;
                sat_q       <= y_clip;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fir_filter_prog.sv
// Directed bench for fir_filter_prog: default instance plus two small
// saturation/rounding instances, all with hand-computed expected results.
module tb_fir_filter_prog;
    logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1;
    int   n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    fir_filter_prog_if #(.COEF_WIDTH(3), .DATA_IN_WIDTH(8), .DATA_OUT_WIDTH(19), .ADDR_W(2)) b1 ();
    fir_filter_prog_if #(.COEF_WIDTH(8), .DATA_IN_WIDTH(8), .DATA_OUT_WIDTH(12), .ADDR_W(2)) b2 ();
    fir_filter_prog_if #(.COEF_WIDTH(8), .DATA_IN_WIDTH(8), .DATA_OUT_WIDTH(12), .ADDR_W(2)) b3 ();

    fir_filter_prog u_dut (.clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(b1.slave));
    fir_filter_prog #(.NUM_TAPS(4), .COEF_WIDTH(8), .DATA_IN_WIDTH(8), .DATA_OUT_WIDTH(12),
                      .OUT_SHIFT(0))
        u_sat (.clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(b2.slave));
    fir_filter_prog #(.NUM_TAPS(4), .COEF_WIDTH(8), .DATA_IN_WIDTH(8), .DATA_OUT_WIDTH(12),
                      .OUT_SHIFT(2))
        u_rnd (.clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(b3.slave));

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input int a, input int v);
        b1.coef_wr_en = 1'b1;
        b1.coef_addr  = 2'(a);
        b1.coef_wdata = 3'(v);
        tick();
        b1.coef_wr_en = 1'b0;
    endtask

    task automatic send1(input int v, input int exp, input string tag);
        b1.in_valid  = 1'b1;
        b1.data_in   = 8'(v);
        b1.out_ready = 1'b1;
        tick();
        chk({tag, "_vld"}, b1.out_valid, 1);
        chk(tag, b1.data_out, exp);
    endtask

    task automatic idle1(input string tag);
        b1.in_valid = 1'b0;
        tick();
        chk(tag, b1.out_valid, 0);
    endtask

    initial begin
        b1.coef_wr_en = 0; b1.coef_addr = 0; b1.coef_wdata = 0;
        b1.in_valid = 0; b1.data_in = 0; b1.out_ready = 0;
        b2.coef_wr_en = 0; b2.coef_addr = 0; b2.coef_wdata = 0;
        b2.in_valid = 0; b2.data_in = 0; b2.out_ready = 0;
        b3.coef_wr_en = 0; b3.coef_addr = 0; b3.coef_wdata = 0;
        b3.in_valid = 0; b3.data_in = 0; b3.out_ready = 0;

        // reset state
        repeat (2) tick();
        chk("rst_vld", b1.out_valid, 0);
        chk("rst_data", b1.data_out, 0);
        chk("rst_sat", b1.sat_flag, 0);
        chk("rst_rdy", b1.in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("rdy_after_rst", b1.in_ready, 1);
        tick();

        // saturation (shift 0) and rounding (shift 2) instances
        for (int i = 0; i < 4; i++) begin
            b2.coef_wr_en = 1'b1; b2.coef_addr = 2'(i); b2.coef_wdata = 8'sd127;
            tick();
        end
        b2.coef_wr_en = 1'b0;
        b3.coef_wr_en = 1'b1; b3.coef_addr = 2'd0; b3.coef_wdata = 8'sd3;
        tick();
        b3.coef_wr_en = 1'b0;
        b2.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b2.in_valid = 1'b1; b2.data_in = 8'sd127;
            tick();
            chk("sat_pos", b2.data_out, 2047);
            chk("sat_pos_flag", b2.sat_flag, 1);
        end
        b2.data_in = -8'sd128; tick();
        tick();
        chk("sat_mid", b2.data_out, -254);
        chk("sat_mid_flag", b2.sat_flag, 0);
        tick(); tick();
        chk("sat_neg", b2.data_out, -2048);
        chk("sat_neg_flag", b2.sat_flag, 1);
        b2.in_valid = 1'b0;
        b3.out_ready = 1'b1; b3.in_valid = 1'b1;
        b3.data_in = 8'sd1; tick();
        chk("rnd_1", b3.data_out, 1);
        chk("rnd_1_flag", b3.sat_flag, 0);
        b3.data_in = 8'sd2; tick();
        chk("rnd_half", b3.data_out, 2);
        b3.data_in = -8'sd1; tick();
        chk("rnd_neg", b3.data_out, -1);
        b3.in_valid = 1'b0;

        // impulse response
        wr1(0, 1); wr1(1, 2); wr1(2, 3);
        send1(1, 1, "imp0"); send1(0, 2, "imp1"); send1(0, 3, "imp2"); send1(0, 0, "imp3");
        idle1("imp_drain");

        // step with a clk_en freeze mid-stream
        send1(1, 1, "step0"); send1(1, 3, "step1");
        b1.data_in = 8'sd0; clk_en = 1'b0;
        #1;
        chk("freeze_rdy", b1.in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("freeze_vld", b1.out_valid, 1);
            chk("freeze_data", b1.data_out, 3);
        end
        clk_en = 1'b1;
        send1(0, 5, "step2"); send1(0, 3, "step3"); send1(0, 0, "step4");
        idle1("step_drain");

        // signed coefficients under backpressure
        wr1(0, -4); wr1(1, 3); wr1(2, 1);
        send1(-128, 512, "sgn0");
        b1.out_ready = 1'b0; b1.data_in = 8'sd127;
        #1;
        chk("bp_rdy", b1.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_data", b1.data_out, 512);
            chk("bp_vld", b1.out_valid, 1);
            chk("bp_rdy_hold", b1.in_ready, 0);
        end
        send1(127, -892, "sgn1"); send1(0, 253, "sgn2");
        idle1("sgn_drain");

        // coefficient write colliding with an accept, then an out-of-range write
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        wr1(0, 1); wr1(1, 2); wr1(2, 3);
        b1.coef_wr_en = 1'b1; b1.coef_addr = 2'd0; b1.coef_wdata = 3'sd2;
        send1(5, 5, "coef_old");
        b1.coef_wr_en = 1'b0;
        send1(1, 12, "coef_new");
        b1.in_valid = 1'b0;
        b1.coef_wr_en = 1'b1; b1.coef_addr = 2'd3; b1.coef_wdata = -3'sd1;
        tick();
        b1.coef_wr_en = 1'b0;
        send1(0, 17, "coef_badaddr");

        // synchronous reset while a result is pending
        b1.in_valid = 1'b0; rst_n = 1'b0;
        tick();
        chk("mrst_vld", b1.out_valid, 0);
        chk("mrst_data", b1.data_out, 0);
        chk("mrst_rdy", b1.in_ready, 0);
        rst_n = 1'b1;
        send1(1, 0, "mrst_cleared");
        chk("mrst_sat", b1.sat_flag, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
